// File: rtl/pixel_serializer.sv
// pixel_serializer
//   Parallel-in, serial-out feeder for the search-window pixel pipeline.
//   One row of NPIX pixels is accepted per load handshake into a shadow
//   buffer. Each row then moves to the active buffer and streams out one
//   pixel per enabled cycle. Because the shadow can refill while the active
//   row drains, back-to-back rows stream out with no gaps.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   en         in   downstream advance; a pixel is consumed when en & out_valid
//   load_valid in   row offered on load_data
//   load_ready out  shadow buffer is empty and can take a row
//   load_data  in   NPIX*DWIDTH row; pixel k at [k*DWIDTH +: DWIDTH]
//   out_valid  out  out_data holds a valid pixel
//   out_data   out  current pixel (register bits)
//   out_last   out  out_data is the final emitted pixel of its row
//
// Configuration
//   PIXEL_SERIALIZER_MSB_FIRST_EN : when defined, pixels are emitted from
//   NPIX-1 down to 0 instead of 0 up to NPIX-1. Handshake timing is unchanged.
module pixel_serializer #(
  parameter int NPIX   = 16,
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [NPIX*DWIDTH-1:0]   load_data,
  output logic                     out_valid,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_last
);

  localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(NPIX - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                   state_q,    state_d;
  logic [NPIX*DWIDTH-1:0]   act_buf_q,  act_buf_d;
  logic [CWIDTH-1:0]        act_cnt_q,  act_cnt_d;
  logic [NPIX*DWIDTH-1:0]   shd_buf_q,  shd_buf_d;
  logic                     shd_full_q, shd_full_d;

  logic accept;
  logic at_last;
  logic xfer;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      act_buf_q  <= '0;
      act_cnt_q  <= '0;
      shd_buf_q  <= '0;
      shd_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_buf_q  <= act_buf_d;
      act_cnt_q  <= act_cnt_d;
      shd_buf_q  <= shd_buf_d;
      shd_full_q <= shd_full_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    act_buf_d  = act_buf_q;
    act_cnt_d  = act_cnt_q;
    shd_buf_d  = shd_buf_q;
    shd_full_d = shd_full_q;

    // An accept needs an empty shadow and a transfer needs a full one,
    // so the two never coincide and may be evaluated independently.
    accept  = load_valid & ~shd_full_q;
    at_last = (act_cnt_q == LAST_IDX);
    xfer    = shd_full_q & ((state_q == IDLE) | (en & at_last));

    if (accept) begin
      shd_buf_d  = load_data;
      shd_full_d = 1'b1;
    end

    if (xfer) begin
      act_buf_d  = shd_buf_q;
      act_cnt_d  = '0;
      state_d    = SHIFT;
      shd_full_d = 1'b0;
    end else if ((state_q == SHIFT) && en) begin
      if (at_last) begin
        // Row finished with nothing queued behind it.
        state_d = IDLE;
      end else begin
`ifdef PIXEL_SERIALIZER_MSB_FIRST_EN
        act_buf_d = act_buf_q << DWIDTH;
`else
        act_buf_d = act_buf_q >> DWIDTH;
`endif
        act_cnt_d = act_cnt_q + CWIDTH'(1);
      end
    end
  end

  // Outputs are decodes of registers only; load_ready has no path from
  // load_valid or en.
  assign load_ready = ~shd_full_q;
  assign out_valid  = (state_q == SHIFT);
  assign out_last   = (state_q == SHIFT) & (act_cnt_q == LAST_IDX);
`ifdef PIXEL_SERIALIZER_MSB_FIRST_EN
  assign out_data   = act_buf_q[NPIX*DWIDTH-1 -: DWIDTH];
`else
  assign out_data   = act_buf_q[DWIDTH-1:0];
`endif

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer with NPIX=4, DWIDTH=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pixel_serializer;

  localparam int NPIX   = 4;
  localparam int DWIDTH = 8;
  localparam int CWIDTH = 3;

  logic                   clk;
  logic                   rst_n;
  logic                   en;
  logic                   load_valid;
  logic                   load_ready;
  logic [NPIX*DWIDTH-1:0] load_data;
  logic                   out_valid;
  logic [DWIDTH-1:0]      out_data;
  logic                   out_last;

  int n_chk;
  int n_err;

  pixel_serializer #(
    .NPIX   (NPIX),
    .DWIDTH (DWIDTH),
    .CWIDTH (CWIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected k-th emitted pixel of a row, in emission order.
  function automatic logic [7:0] exp_pix(input logic [31:0] row, input int k);
`ifdef PIXEL_SERIALIZER_MSB_FIRST_EN
    return row[(NPIX-1-k)*8 +: 8];
`else
    return row[k*8 +: 8];
`endif
  endfunction

  task automatic chk_pix(input string tag, input logic [31:0] row, input int k);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(exp_pix(row, k)));
    chk({tag, "_last"},  32'(out_last),  (k == NPIX-1) ? 32'd1 : 32'd0);
  endtask

  // Checks the current pixel and the following NPIX-1, advancing en=1.
  task automatic emit_row(input string tag, input logic [31:0] row);
    for (int k = 0; k < NPIX; k++) begin
      chk_pix($sformatf("%s_p%0d", tag, k), row, k);
      tick();
      load_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    en         = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    #1;

    // ---- reset values
    do_reset();
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_data",  32'(out_data),   32'd0);
    chk("rst_last",  32'(out_last),   32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);

    // ---- single row, latency and ordering
    en = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'h44332211;
    tick();
    load_valid = 1'b0;
    chk("t1_ready_low",  32'(load_ready), 32'd0);
    chk("t1_not_valid",  32'(out_valid),  32'd0);
    tick();
    chk("t1_ready_back", 32'(load_ready), 32'd1);
    emit_row("t1", 32'h44332211);
    chk("t1_idle_after", 32'(out_valid), 32'd0);
    tick();
    chk("t1_idle_after2", 32'(out_valid), 32'd0);

    // ---- two back-to-back rows, no gap
    load_valid = 1'b1;
    load_data  = 32'h04030201;
    tick();
    load_data  = 32'h08070605;
    tick();
    // Row B is accepted at the first edge inside emit_row, which then drops load_valid.
    emit_row("t2a", 32'h04030201);
    emit_row("t2b", 32'h08070605);
    chk("t2_idle_after", 32'(out_valid), 32'd0);

    // ---- en stall holds the current pixel
    load_valid = 1'b1;
    load_data  = 32'h44332211;
    tick();
    load_valid = 1'b0;
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_stall%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("t3_stall%0d_data", i),  32'(out_data),  32'h11);
      tick();
    end
    en = 1'b1;
    emit_row("t3", 32'h44332211);
    chk("t3_idle_after", 32'(out_valid), 32'd0);

    // ---- full shadow refuses a further row
    load_valid = 1'b1;
    load_data  = 32'h44332211;
    tick();
    load_valid = 1'b0;
    tick();
    chk_pix("t4_a0", 32'h44332211, 0);
    load_valid = 1'b1;
    load_data  = 32'hDDCCBBAA;
    tick();
    chk("t4_ready_full", 32'(load_ready), 32'd0);
    chk_pix("t4_a1", 32'h44332211, 1);
    load_data  = 32'h99887766;
    tick();
    chk("t4_ready_still", 32'(load_ready), 32'd0);
    chk_pix("t4_a2", 32'h44332211, 2);
    tick();
    load_valid = 1'b0;
    chk_pix("t4_a3", 32'h44332211, 3);
    tick();
    emit_row("t4c", 32'hDDCCBBAA);
    chk("t4_idle_after", 32'(out_valid), 32'd0);
    chk("t4_ready_end",  32'(load_ready), 32'd1);

    // ---- reset mid-row discards both buffers
    load_valid = 1'b1;
    load_data  = 32'h44332211;
    tick();
    load_valid = 1'b0;
    tick();
    load_valid = 1'b1;
    load_data  = 32'h0F0E0D0C;
    tick();
    load_valid = 1'b0;
    tick();
    chk_pix("t5_p2", 32'h44332211, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_valid", 32'(out_valid),  32'd0);
    chk("t5_ready", 32'(load_ready), 32'd1);
    chk("t5_data",  32'(out_data),   32'd0);
    chk("t5_last",  32'(out_last),   32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t5_quiet%0d", i), 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
